// File: rtl/polygon_edge_sequencer.sv
// ============================================================================
//  Module      : polygon_edge_sequencer
//  Description : Computes the bounding-box minimum of a 2..MAX_VERT vertex
//                polygon and issues its closing edges, box-relative, to a
//                line drawer. Optional bbox size outputs: POLY_BBOX_OUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module polygon_edge_sequencer #(
    parameter int COORD_W  = 8,
    parameter int MAX_VERT = 4,
    parameter int VCNT_W   = 3
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            bla_en,
    input  logic [VCNT_W-1:0]               vert_count,
    input  logic [2*COORD_W*MAX_VERT-1:0]   coordinates,
    input  logic                            draw_done,
    output logic                            reset_buff,
    output logic [COORD_W-1:0]              x0,
    output logic [COORD_W-1:0]              y0,
    output logic [COORD_W-1:0]              x1,
    output logic [COORD_W-1:0]              y1,
    output logic                            draw_en,
    output logic                            bla_done,
`ifdef POLY_BBOX_OUT_EN
    output logic [COORD_W-1:0]              bbox_w,
    output logic [COORD_W-1:0]              bbox_h,
`endif
    output logic                            busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MIN_CALC = 3'd1,
        S_RESET    = 3'd2,
        S_DRAW     = 3'd3,
        S_WAIT     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [VCNT_W-1:0] c_max_n = VCNT_W'(MAX_VERT);

    state_t                          state_q, state_d;
    logic [2*COORD_W*MAX_VERT-1:0]   verts_q;
    logic [VCNT_W-1:0]               n_q;
    logic [VCNT_W-1:0]               idx_q;
    logic [COORD_W-1:0]              min_x_q, min_y_q;

    logic [VCNT_W-1:0]               w_n_eff, w_n_m1, w_bidx, w_last_k;
    logic [COORD_W-1:0]              w_ax, w_ay, w_bx, w_by;
    logic [COORD_W-1:0]              w_minx_nxt, w_miny_nxt;
    logic                            w_first, w_last_vert;

    function automatic logic [COORD_W-1:0] get_coord(
        input logic [2*COORD_W*MAX_VERT-1:0] v,
        input logic [VCNT_W-1:0]             i,
        input logic                          is_y
    );
        get_coord = '0;
        for (int j = 0; j < MAX_VERT; j++) begin
            if (i == VCNT_W'(j)) begin
                if (is_y)
                    get_coord = v[2*COORD_W*j+COORD_W +: COORD_W];
                else
                    get_coord = v[2*COORD_W*j +: COORD_W];
            end
        end
    endfunction

    assign w_n_eff     = (vert_count > c_max_n) ? c_max_n : vert_count;
    assign w_n_m1      = n_q - VCNT_W'(1);
    // Closing edge wraps back to vertex 0; a 2-vertex line has only edge 0.
    assign w_bidx      = (idx_q == w_n_m1) ? '0 : idx_q + VCNT_W'(1);
    assign w_last_k    = (n_q == VCNT_W'(2)) ? '0 : w_n_m1;
    assign w_first     = (idx_q == '0);
    assign w_last_vert = (idx_q == w_n_m1);

    assign w_ax = get_coord(verts_q, idx_q, 1'b0);
    assign w_ay = get_coord(verts_q, idx_q, 1'b1);
    assign w_bx = get_coord(verts_q, w_bidx, 1'b0);
    assign w_by = get_coord(verts_q, w_bidx, 1'b1);

    assign w_minx_nxt = (w_first || (w_ax < min_x_q)) ? w_ax : min_x_q;
    assign w_miny_nxt = (w_first || (w_ay < min_y_q)) ? w_ay : min_y_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            verts_q <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            min_x_q <= '0;
            min_y_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bla_en) begin
                        verts_q <= coordinates;
                        n_q     <= w_n_eff;
                        idx_q   <= '0;
                    end
                end
                S_MIN_CALC: begin
                    min_x_q <= w_minx_nxt;
                    min_y_q <= w_miny_nxt;
                    idx_q   <= idx_q + VCNT_W'(1);
                end
                S_RESET: idx_q <= '0;
                S_WAIT:  idx_q <= idx_q + VCNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef POLY_BBOX_OUT_EN
    logic [COORD_W-1:0] max_x_q, max_y_q, bbox_w_q, bbox_h_q;
    logic [COORD_W-1:0] w_maxx_nxt, w_maxy_nxt;

    assign w_maxx_nxt = (w_first || (w_ax > max_x_q)) ? w_ax : max_x_q;
    assign w_maxy_nxt = (w_first || (w_ay > max_y_q)) ? w_ay : max_y_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            max_x_q  <= '0;
            max_y_q  <= '0;
            bbox_w_q <= '0;
            bbox_h_q <= '0;
        end else if (state_q == S_MIN_CALC) begin
            max_x_q <= w_maxx_nxt;
            max_y_q <= w_maxy_nxt;
            // Loaded on the final vertex so the size is visible from RESET on.
            if (w_last_vert) begin
                bbox_w_q <= w_maxx_nxt - w_minx_nxt;
                bbox_h_q <= w_maxy_nxt - w_miny_nxt;
            end
        end else if (state_q == S_DONE) begin
            bbox_w_q <= '0;
            bbox_h_q <= '0;
        end
    end

    assign bbox_w = bbox_w_q;
    assign bbox_h = bbox_h_q;
`endif

    always_comb begin
        state_d    = state_q;
        reset_buff = 1'b0;
        draw_en    = 1'b0;
        bla_done   = 1'b0;
        x0         = '0;
        y0         = '0;
        x1         = '0;
        y1         = '0;
        case (state_q)
            S_IDLE: begin
                if (bla_en)
                    state_d = (w_n_eff < VCNT_W'(2)) ? S_DONE : S_MIN_CALC;
            end
            S_MIN_CALC: begin
                if (w_last_vert)
                    state_d = S_RESET;
            end
            S_RESET: begin
                reset_buff = 1'b1;
                state_d    = S_DRAW;
            end
            S_DRAW: begin
                draw_en = 1'b1;
                x0      = w_ax - min_x_q;
                y0      = w_ay - min_y_q;
                x1      = w_bx - min_x_q;
                y1      = w_by - min_y_q;
                if (draw_done)
                    state_d = (idx_q == w_last_k) ? S_DONE : S_WAIT;
            end
            S_WAIT: state_d = S_DRAW;
            S_DONE: begin
                bla_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule

`default_nettype wire
